// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the signals around the RAM port arbiter: the instruction-fetch
// request port (i_*), the load/store request port (d_*), the RAM strobe
// port (mem_*) and the busy flag.
//   slave  : arbiter view (takes requests and read data, drives results and strobes)
//   master : environment view (CPU requesters plus RAM)
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unclocked byte-addressed RAM port between the instruction-fetch
// port and the load/store port. Each granted request spends exactly one
// cycle in ACCESS, where a single-cycle read or write strobe is issued
// (suppressed for misaligned or out-of-range addresses). The requester's
// done pulse, error flag and registered read data follow one cycle later.
// Data wins arbitration unless it has been granted STARVE_LIMIT times in a
// row while a fetch was waiting.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave: i_* fetch port, d_* load/store
//            port, mem_* RAM port, busy (high while in ACCESS)
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES    = 101,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q,   state_d;
  logic [3:0]  starve_q,  starve_d;
  logic        sel_i_q,   sel_i_d;     // latched winner: 1 = fetch port
  logic [31:0] addr_q,    addr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic        we_q,      we_d;
  logic        err_q,     err_d;
  logic        i_done_q,  i_done_d;
  logic        d_done_q,  d_done_d;
  logic        i_err_q,   i_err_d;
  logic        d_err_q,   d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // A port whose done is showing this cycle is still holding the request
  // it just completed, so it must not be granted again.
  logic        i_elig, d_elig, pick_i, grant;
  logic [31:0] addr_sel;

  assign i_elig   = bus.i_req && !i_done_q;
  assign d_elig   = bus.d_req && !d_done_q;
  assign pick_i   = i_elig && (!d_elig || (starve_q == LIMIT));
  assign grant    = (state_q == IDLE) && (i_elig || d_elig);
  assign addr_sel = pick_i ? bus.i_addr : bus.d_addr;

  // State register (also holds every datapath and output register)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      sel_i_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      sel_i_q   <= sel_i_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      err_q     <= err_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_elig || d_elig) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, starvation counter and completion registers
  always_comb begin
    sel_i_d   = sel_i_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    err_d     = err_q;
    starve_d  = starve_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    if (grant) begin
      sel_i_d = pick_i;
      addr_d  = addr_sel;
      we_d    = pick_i ? 1'b0  : bus.d_we;
      wdata_d = pick_i ? 32'h0 : bus.d_wdata;
      err_d   = (addr_sel[1:0] != 2'b00) || (addr_sel > MAX_ADDR);
      if (pick_i) begin
        starve_d = '0;
      end else if (bus.i_req) begin
        // Count data grants that overtook a raised fetch request.
        starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
      end else begin
        starve_d = '0;
      end
    end

    if (state_q == ACCESS) begin
      i_done_d = sel_i_q;
      d_done_d = !sel_i_q;
      i_err_d  = sel_i_q  && err_q;
      d_err_d  = !sel_i_q && err_q;
      if (!err_q && !we_q) begin
        if (sel_i_q) i_rdata_d = bus.mem_rdata;
        else         d_rdata_d = bus.mem_rdata;
      end
    end
  end

  // Output logic: RAM strobes exist only during an error-free ACCESS.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.busy      = (state_q == ACCESS);
    if ((state_q == ACCESS) && !err_q) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.mem_read  = !we_q;
      bus.mem_write = we_q;
    end
  end

  assign bus.i_rdata = i_rdata_q;
  assign bus.i_done  = i_done_q;
  assign bus.i_err   = i_err_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_done  = d_done_q;
  assign bus.d_err   = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (MEM_BYTES=101, STARVE_LIMIT=4)
// with a behavioural byte RAM. Expected RAM accesses and completions are
// queued when a request is driven and checked by a monitor as they appear.
module tb_mem_port_arbiter;

  localparam int MEM_BYTES = 101;

  logic clk;
  logic reset_n;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          instr;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    bit          instr;
    bit          err;
    logic [31:0] rdata;
  } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- RAM model ----------------
  logic [7:0] ram [0:MEM_BYTES-1];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a <= 32'(MEM_BYTES - 4))
      return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    return 32'h0;
  endfunction

  assign bus.mem_rdata = bus.mem_read ? rd_word(bus.mem_addr) : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr <= 32'(MEM_BYTES - 4)) begin
      ram[bus.mem_addr]   = bus.mem_wdata[7:0];
      ram[bus.mem_addr+1] = bus.mem_wdata[15:8];
      ram[bus.mem_addr+2] = bus.mem_wdata[23:16];
      ram[bus.mem_addr+3] = bus.mem_wdata[31:24];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    acc_t  a;
    done_t d;
    #2;
    if (reset_n) begin
      if (bus.mem_read && bus.mem_write) chk("strobes_exclusive", 32'd1, 32'd0);
      if (bus.mem_read || bus.mem_write) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access_addr", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          a = acc_q.pop_front();
          chk("acc_we", {31'b0, bus.mem_write}, {31'b0, a.we});
          chk("acc_addr", bus.mem_addr, a.addr);
          if (a.we) chk("acc_wdata", bus.mem_wdata, a.wdata);
        end
      end
      if (bus.i_done && bus.d_done) chk("single_done", 32'd1, 32'd0);
      if (bus.i_done || bus.d_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done_i", {31'b0, bus.i_done}, 32'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_port_i", {31'b0, bus.i_done}, {31'b0, d.instr});
          if (bus.i_done) begin
            chk("i_err", {31'b0, bus.i_err}, {31'b0, d.err});
            chk("i_rdata", bus.i_rdata, d.rdata);
          end else begin
            chk("d_err", {31'b0, bus.d_err}, {31'b0, d.err});
            chk("d_rdata", bus.d_rdata, d.rdata);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done(input bit instr, input int exp_lat);
    bit seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (instr ? bus.i_done : bus.d_done) begin
        seen = 1;
        chk("done_latency", 32'(c), 32'(exp_lat));
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    if (!v.exp_err) acc_q.push_back('{v.we, v.addr, v.wdata});
    done_q.push_back('{v.instr, v.exp_err, v.exp_rdata});
    if (v.instr) begin
      bus.i_req  = 1'b1;
      bus.i_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end
    wait_done(v.instr, 1);
    // Keep the request raised through the done cycle: it must not re-issue.
    @(negedge clk);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  // Data wins while the fetch request is raised only at the grant edge.
  task automatic d_round();
    acc_q.push_back('{1'b0, 32'h10, 32'h0});
    done_q.push_back('{1'b0, 1'b0, 32'h12345678});
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    @(negedge clk);
    bus.i_req = 1'b0;
    wait_done(1'b0, 0);
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  // Both raised, fetch expected to win; data follows after fetch's ACCESS.
  task automatic i_round();
    bit iseen = 0, dseen = 0;
    acc_q.push_back('{1'b0, 32'h20, 32'h0});
    done_q.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    acc_q.push_back('{1'b0, 32'h10, 32'h0});
    done_q.push_back('{1'b0, 1'b0, 32'h12345678});
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    for (int c = 0; c < 12 && !(iseen && dseen); c++) begin
      @(negedge clk);
      if (bus.i_done) begin bus.i_req = 1'b0; iseen = 1; end
      if (bus.d_done) begin bus.d_req = 1'b0; dseen = 1; end
    end
    if (!(iseen && dseen)) chk("starve_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[14];

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ram[i] = 8'h00;
    ram[16] = 8'h78; ram[17] = 8'h56; ram[18] = 8'h34; ram[19] = 8'h12;
    ram[96] = 8'hD4; ram[97] = 8'hC3; ram[98] = 8'hB2; ram[99] = 8'hA1;

    tbl[0]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'h12345678};
    tbl[1]  = '{1'b0, 1'b1, 32'h20,       32'hDEADBEEF, 1'b0, 32'h12345678};
    tbl[2]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b0, 32'h11,       32'h0,        1'b1, 32'h12345678};
    tbl[4]  = '{1'b0, 1'b0, 32'h62,       32'h0,        1'b1, 32'h12345678};
    tbl[5]  = '{1'b0, 1'b0, 32'h60,       32'h0,        1'b0, 32'hA1B2C3D4};
    tbl[6]  = '{1'b1, 1'b0, 32'h64,       32'h0,        1'b1, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 1'b1, 32'h11,       32'h55555555, 1'b1, 32'hA1B2C3D4};
    tbl[9]  = '{1'b0, 1'b1, 32'h60,       32'h11223344, 1'b0, 32'hA1B2C3D4};
    tbl[10] = '{1'b1, 1'b0, 32'h60,       32'h0,        1'b0, 32'h11223344};
    tbl[11] = '{1'b0, 1'b0, 32'h20,       32'h0,        1'b0, 32'hDEADBEEF};
    tbl[12] = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'h12345678};
    tbl[13] = '{1'b0, 1'b1, 32'h64,       32'h99999999, 1'b1, 32'hDEADBEEF};

    reset_n     = 1'b0;
    bus.i_req   = 1'b0; bus.i_addr = 32'h0;
    bus.d_req   = 1'b0; bus.d_we   = 1'b0;
    bus.d_addr  = 32'h0; bus.d_wdata = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_i_rdata",   bus.i_rdata, 32'h0);
    chk("rst_d_rdata",   bus.d_rdata, 32'h0);
    chk("rst_i_done",    {31'b0, bus.i_done}, 32'h0);
    chk("rst_d_done",    {31'b0, bus.d_done}, 32'h0);
    chk("rst_mem_read",  {31'b0, bus.mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 32'h0);
    chk("rst_busy",      {31'b0, bus.busy}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // Simultaneous requests: data first, then fetch.
    acc_q.push_back('{1'b0, 32'h20, 32'h0});
    done_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    acc_q.push_back('{1'b0, 32'h10, 32'h0});
    done_q.push_back('{1'b1, 1'b0, 32'h12345678});
    begin
      bit iseen = 0, dseen = 0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      for (int c = 0; c < 12 && !(iseen && dseen); c++) begin
        @(negedge clk);
        if (bus.d_done) begin bus.d_req = 1'b0; dseen = 1; end
        if (bus.i_done) begin bus.i_req = 1'b0; iseen = 1; end
      end
      if (!(iseen && dseen)) chk("contention_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end

    // Starvation: four overtaking data grants, then fetch; twice over.
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 4; r++) d_round();
      i_round();
    end

    // Reset during a store's ACCESS cycle.
    acc_q.push_back('{1'b1, 32'h30, 32'hCAFEF00D});
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_write", {31'b0, bus.mem_write}, 32'h0);
    chk("arst_mem_addr",  bus.mem_addr, 32'h0);
    chk("arst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("arst_busy",      {31'b0, bus.busy}, 32'h0);
    chk("arst_i_rdata",   bus.i_rdata, 32'h0);
    chk("arst_d_rdata",   bus.d_rdata, 32'h0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    run_vec('{1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h12345678});
    run_vec('{1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h11223344});

    repeat (2) @(negedge clk);
    chk("acc_q_drained",  32'(acc_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
